// File: rtl/key_press_counter_if.sv
// Pushbutton-to-counter bus: raw active-low keys in, debounced pulses,
// held levels and the running press count out.
// Ports: key_n[1:0] (raw, active-low), press_pulse[1:0], key_state[1:0], count[WIDTH-1:0].
// Latency: n/a (signal bundle only). Backpressure: none, outputs are free-running levels/pulses.
interface key_press_counter_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       key_n;        // [0]=up, [1]=down, low = pressed
   logic [1:0]       press_pulse;  // one cycle per validated press
   logic [1:0]       key_state;    // debounced level, 1 = held
   logic [WIDTH-1:0] count;        // up/down press count

   // master drives the buttons and observes results; slave is the counter block
   modport master (
      output key_n,
      input  press_pulse,
      input  key_state,
      input  count
   );

   modport slave (
      input  key_n,
      output press_pulse,
      output key_state,
      output count
   );
endinterface

// File: rtl/key_press_counter.sv
// Debounces two active-low pushbuttons and keeps a modulo-2^WIDTH up/down press count.
// Latency: key_n low -> press_pulse high after DEBOUNCE_CYCLES+3 cycles; count one cycle later.
// Backpressure: none; every validated press is counted, simultaneous up+down cancel.
// Ports: CLOCK_50 (clock), reset (sync, active-high), bus (slave modport:
//        key_n in, press_pulse/key_state/count out).
module key_press_counter #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,  // must be >= 2
   parameter int WIDTH           = 8
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   key_press_counter_if.slave    bus
);

   localparam int TW = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Two-flop synchronizers; reset to 1 so a reset looks like "released".
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;
   logic [1:0] press;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= bus.key_n;
         sync2_q <= sync1_q;
      end
   end

   assign press = ~sync2_q;

   logic [1:0] pulse;
   logic [1:0] held;

   for (genvar k = 0; k < 2; k++) begin : g_key
      state_t        state_q, state_d;
      logic [TW-1:0] timer_q, timer_d;
      logic          pulse_q, pulse_d;
      logic          held_q,  held_d;
      logic          at_end;

      assign at_end = (timer_q == TW'(DEBOUNCE_CYCLES - 1));

      // State register (outputs registered alongside the state)
      always_ff @(posedge CLOCK_50) begin
         if (reset) begin
            state_q <= RELEASED;
            timer_q <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
         end
      end

      // Next-state logic: any disagreement during a wait aborts back to the
      // previous stable state, so only an uninterrupted level is accepted.
      always_comb begin
         state_d = state_q;
         timer_d = timer_q;
         case (state_q)
            RELEASED: begin
               if (press[k]) begin
                  state_d = PRESS_WAIT;
                  timer_d = '0;
               end
            end
            PRESS_WAIT: begin
               if (!press[k])   state_d = RELEASED;
               else if (at_end) state_d = PRESSED;
               else             timer_d = timer_q + TW'(1);
            end
            PRESSED: begin
               if (!press[k]) begin
                  state_d = RELEASE_WAIT;
                  timer_d = '0;
               end
            end
            RELEASE_WAIT: begin
               if (press[k])    state_d = PRESSED;
               else if (at_end) state_d = RELEASED;
               else             timer_d = timer_q + TW'(1);
            end
            default: state_d = RELEASED;
         endcase
      end

      // Output logic: pulse only on the PRESS_WAIT->PRESSED edge, so a bounce
      // back from RELEASE_WAIT never re-fires.
      always_comb begin
         pulse_d = (state_q == PRESS_WAIT) && (state_d == PRESSED);
         held_d  = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      end

      assign pulse[k] = pulse_q;
      assign held[k]  = held_q;
   end

   // Up/down count, wrapping modulo 2^WIDTH.
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      case (pulse)
         2'b01:   count_d = count_q + WIDTH'(1);
         2'b10:   count_d = count_q - WIDTH'(1);
         default: count_d = count_q;   // neither, or both cancel
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign bus.press_pulse = pulse;
   assign bus.key_state   = held;
   assign bus.count       = count_q;

endmodule
